kbd_scan_fifo: RTL
==================

// Module: kbd_scan_fifo
// PURPOSE
//   Buffers scan codes between keyinterface (upstream) and the 8255 port A / IRQ1 path (downstream).
//   Upstream: captures each byte presented on keyinterface pa/irq1 and acknowledges it on pb7.
//   Downstream: presents the oldest byte on pa_out with irq_out high; the CPU pops it with a PB7 pulse.
//   Prevents scan-code loss when the CPU services IRQ1 slowly.
// PARAMETERS
//   DEPTH        16   FIFO entries; power of two, >= 2
//   AW           4    pointer width, log2(DEPTH)
//   ACK_TIMEOUT  255  max cycles kbd_ack stays high waiting for kbd_irq to drop
// PORTS
//   pclk       in   1      system clock
//   reset      in   1      asynchronous, active-high reset
//   kbd_data   in   8      scan code from keyinterface pa
//   kbd_irq    in   1      byte-valid from keyinterface irq1; level, held until acknowledged
//   kbd_ack    out  1      acknowledge to keyinterface pb7
//   cpu_ack    in   1      8255 PB7; rising edge pops the head byte
//   flush      in   1      synchronous clear of FIFO contents
//   pa_out     out  8      head byte toward 8255 port A
//   irq_out    out  1      IRQ1 toward the PIC
//   count      out  AW+1   current occupancy, 0..DEPTH
//   ack_err    out  1      sticky: upstream handshake timed out
// BEHAVIOUR
//   Reset: kbd_ack=0, irq_out=0, pa_out=8'h00, count=0, ack_err=0; both FSMs idle; pointers 0.
//   Upstream FSM (U_IDLE, U_ACK):
//     U_IDLE: kbd_irq=1 && count<DEPTH -> push kbd_data the same cycle, go to U_ACK.
//             kbd_irq=1 && count==DEPTH -> stay in U_IDLE, no ack; backpressure, byte stays pending upstream.
//     U_ACK:  kbd_ack=1 (registered, high from the cycle after the push).
//             kbd_irq=0 -> go to U_IDLE, kbd_ack=0 next cycle.
//             Timer reaches ACK_TIMEOUT -> set ack_err, go to U_IDLE. No second push of the same byte.
//   Downstream FSM (D_EMPTY, D_SHOW, D_HOLD):
//     D_EMPTY: count>0 -> load pa_out=head, go to D_SHOW (irq_out=1 next cycle).
//     D_SHOW:  cpu_ack rising edge (registered prev-sample compare) -> pop, irq_out=0, go to D_HOLD.
//     D_HOLD:  wait for cpu_ack=0. Then go to D_SHOW if count>0 (pa_out reloaded), else D_EMPTY.
//     Exactly one pop per cpu_ack rising edge. A cpu_ack rising edge while in D_EMPTY is ignored.
//   pa_out stays stable while irq_out=1. pa_out keeps its last value in D_EMPTY.
//   Latency: push at cycle N -> irq_out=1 at N+2 when the FIFO was empty.
//   Push and pop in the same cycle: both occur, count unchanged.
//     Full-check uses pre-pop count, so a full FIFO refuses the push that cycle.
//   Pointers wrap modulo DEPTH. count is width AW+1 and never exceeds DEPTH or goes below 0.
//   flush: pointers=0, count=0, irq_out=0, downstream FSM -> D_EMPTY.
//     A push in the same cycle is discarded. An upstream U_ACK handshake still completes.
//     flush does not clear ack_err; only reset clears it.
//   Asynchronous reset mid-handshake: kbd_ack drops immediately; the byte is lost and keyinterface re-presents it.
// STRUCTURE
//   kbd_pkg: upstream/downstream state encodings (localparams), default DEPTH/AW/ACK_TIMEOUT.
//   Sub-module kbd_fifo_mem: DEPTH x 8 register array with wr_en/wr_ptr/rd_ptr and async read of head.
//   Top level holds both FSMs, the pointers/count, the cpu_ack edge detector and the timeout counter.
// TESTING
//   1. Reset, then drive kbd_data=8'h1C with kbd_irq=1; drop kbd_irq when kbd_ack=1
//      -> count=1, irq_out=1, pa_out=8'h1C.
//   2. Push 8'h01..8'h10 (16 bytes) with no cpu_ack, then present 8'h11
//      -> count=16, kbd_ack stays 0 for 8'h11.
//      Then pulse cpu_ack -> 8'h11 accepted, count=16, pa_out=8'h02.
//   3. Hold cpu_ack=1 for 10 cycles with 3 bytes queued -> exactly one pop (count 3->2).
//      irq_out re-asserts only after cpu_ack=0.
//   4. Push in the same cycle as a pop, with count=5 -> count stays 5.
//      Byte order is preserved across a pointer wrap (push 20, pop 20, compare).
//   5. Hold kbd_irq=1 after ack for 300 cycles -> ack_err=1 and only one byte pushed.
//      Then flush -> count=0, irq_out=0, ack_err still 1.
//   6. Assert reset while kbd_ack=1 and irq_out=1 -> all outputs are at reset values in the same cycle.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared state encodings and default sizing for the keyboard scan-code FIFO.
package kbd_pkg;

  localparam int DEPTH_DEF       = 16;
  localparam int AW_DEF          = 4;
  localparam int ACK_TIMEOUT_DEF = 255;

  localparam logic       U_IDLE  = 1'b0;
  localparam logic       U_ACK   = 1'b1;

  localparam logic [1:0] D_EMPTY = 2'd0;
  localparam logic [1:0] D_SHOW  = 2'd1;
  localparam logic [1:0] D_HOLD  = 2'd2;

endpackage

// File: rtl/kbd_fifo_mem.sv
// DEPTH x 8 scan-code storage: synchronous write, asynchronous read of the head entry.
module kbd_fifo_mem
  import kbd_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          pclk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_ptr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_ptr,
  output logic [7:0]    rd_data
);

  logic [7:0] r_mem [DEPTH];

  // NOTE: the array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge pclk) begin
    if (wr_en) r_mem[wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[rd_ptr];

endmodule

// File: rtl/kbd_scan_fifo.sv
// Scan-code FIFO between keyinterface (pa/irq1/pb7) and the 8255 port A / IRQ1 path.
module kbd_scan_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int AW          = AW_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_irq,
  output logic        kbd_ack,
  input  logic        cpu_ack,
  input  logic        flush,
  output logic [7:0]  pa_out,
  output logic        irq_out,
  output logic [AW:0] count,
  output logic        ack_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic          r_ustate, w_ustate_nxt;
  logic [1:0]    r_dstate, w_dstate_nxt;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [TW-1:0] r_ack_timer;
  logic          r_cpu_ack_prev, r_irq_stale, r_ack_err;
  logic [7:0]    r_pa_out, w_head;
  logic          w_full, w_accept, w_push, w_pop, w_cpu_rise, w_timeout, w_load;

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  // A byte left pending after a timeout must not be taken twice; wait for irq to drop.
  assign w_accept   = (r_ustate == U_IDLE) && kbd_irq && !w_full && !r_irq_stale;
  assign w_push     = w_accept && !flush;
  assign w_cpu_rise = cpu_ack && !r_cpu_ack_prev;
  assign w_pop      = (r_dstate == D_SHOW) && w_cpu_rise && !flush;
  assign w_timeout  = (r_ustate == U_ACK) && kbd_irq && (r_ack_timer == TW'(ACK_TIMEOUT - 1));
  assign w_load     = (r_dstate != D_SHOW) && (w_dstate_nxt == D_SHOW);

  kbd_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .pclk    (pclk),
    .wr_en   (w_push),
    .wr_ptr  (r_wr_ptr),
    .wr_data (kbd_data),
    .rd_ptr  (r_rd_ptr),
    .rd_data (w_head)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_ustate <= U_IDLE;
      r_dstate <= D_EMPTY;
    end else begin
      r_ustate <= w_ustate_nxt;
      r_dstate <= w_dstate_nxt;
    end
  end

  // NOTE: each always_comb assigns its outputs a default first so no latch is inferred.
  always_comb begin
    w_ustate_nxt = r_ustate;
    case (r_ustate)
      U_IDLE:  if (w_accept) w_ustate_nxt = U_ACK;
      U_ACK:   if (!kbd_irq || w_timeout) w_ustate_nxt = U_IDLE;
      default: w_ustate_nxt = U_IDLE;
    endcase
  end

  always_comb begin
    w_dstate_nxt = r_dstate;
    if (flush) begin
      w_dstate_nxt = D_EMPTY;
    end else begin
      case (r_dstate)
        D_EMPTY: if (r_count != '0) w_dstate_nxt = D_SHOW;
        D_SHOW:  if (w_cpu_rise) w_dstate_nxt = D_HOLD;
        D_HOLD:  if (!cpu_ack) w_dstate_nxt = (r_count != '0) ? D_SHOW : D_EMPTY;
        default: w_dstate_nxt = D_EMPTY;
      endcase
    end
  end

  always_comb begin
    kbd_ack = (r_ustate == U_ACK);
    irq_out = (r_dstate == D_SHOW);
    pa_out  = r_pa_out;
    count   = r_count;
    ack_err = r_ack_err;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_pa_out       <= 8'h00;
      r_cpu_ack_prev <= 1'b0;
      r_ack_timer    <= '0;
      r_irq_stale    <= 1'b0;
      r_ack_err      <= 1'b0;
    end else begin
      r_cpu_ack_prev <= cpu_ack;
      if (w_load) r_pa_out <= w_head;
      r_ack_timer <= (r_ustate == U_ACK) ? r_ack_timer + TW'(1) : '0;
      if (w_timeout) begin
        r_ack_err   <= 1'b1;
        r_irq_stale <= 1'b1;
      end else if (!kbd_irq) begin
        r_irq_stale <= 1'b0;
      end
    end
  end

endmodule
